// File: rtl/dlpre_pkg.sv
// rtl/dlpre_pkg.sv - shared mode encoding and helpers for the universal register
package dlpre_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_SET  = 3'b111
    } mode_t;

    // Shift and rotate modes are the ones that advance the wrap counter
    function automatic logic is_shift(mode_t m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/dlpre_wrapcnt.sv
// rtl/dlpre_wrapcnt.sv - modulo-WIDTH shift counter with registered wrap pulse
module dlpre_wrapcnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic ret,
    input  logic clr,
    input  logic inc,
    output logic wrap
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    // Count shift operations; the WIDTH-th one returns to zero and pulses wrap
    always_ff @(posedge clk) begin
        if (ret || clr) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (inc) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                wrap <= 1'b1;
            end else begin
                cnt  <= cnt + CW'(1);
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/dlpre_ureg.sv
// rtl/dlpre_ureg.sv - universal register with preset/clear, load, shift, rotate
module dlpre_ureg
    import dlpre_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             ret,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] p,
    output logic             sol,
    output logic             sor
    ,
    output logic             wrap
);

    mode_t            op;
    logic [WIDTH-1:0] next_q;
    logic             cnt_clr;
    logic             cnt_inc;

    assign op = mode_t'(mode);

    // Next-state mux: preset beats the enabled operation, otherwise hold
    always_comb begin
        next_q  = q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (pre) begin
            next_q  = PRE_VAL;
            cnt_clr = 1'b1;
        end else if (en) begin
            cnt_inc = is_shift(op);
            case (op)
                MODE_HOLD: next_q = q;
                MODE_LOAD: begin
                    next_q  = d;
                    cnt_clr = 1'b1;
                end
                MODE_SHL:  next_q = {q[WIDTH-2:0], sil};
                MODE_SHR:  next_q = {sir, q[WIDTH-1:1]};
                MODE_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:  next_q = {q[0], q[WIDTH-1:1]};
                MODE_CLR: begin
                    next_q  = '0;
                    cnt_clr = 1'b1;
                end
                MODE_SET: begin
                    next_q  = '1;
                    cnt_clr = 1'b1;
                end
                default:   next_q = q;
            endcase
        end
    end

    // q and its complement are both registered from next_q so p never lags q
    always_ff @(posedge clk) begin
        if (ret) begin
            q <= INIT;
            p <= ~INIT;
        end else begin
            q <= next_q;
            p <= ~next_q;
        end
    end

    assign sol = q[WIDTH-1];
    assign sor = q[0];

    dlpre_wrapcnt #(
        .WIDTH(WIDTH)
    ) u_wrapcnt (
        .clk (clk),
        .ret (ret),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .wrap(wrap)
    );

endmodule

// File: tb/tb_dlpre_ureg.sv
// tb/tb_dlpre_ureg.sv - randomized and directed bench for dlpre_ureg
module tb_dlpre_ureg;

    logic       clk = 1'b0;
    logic       ret = 1'b0;
    logic       pre = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'h00;
    logic       sil = 1'b0;
    logic       sir = 1'b0;
    logic [7:0] q;
    logic [7:0] p;
    logic       sol;
    logic       sor;
    logic       wrap;

    int total = 0;
    int bad = 0;

    logic [7:0] m_q = 8'h00;
    int         m_shifts = 0;
    logic       m_wrap = 1'b0;
    logic       m_valid = 1'b0;

    dlpre_ureg #(.WIDTH(8)) dut (
        .clk (clk),
        .ret (ret),
        .pre (pre),
        .en  (en),
        .mode(mode),
        .d   (d),
        .sil (sil),
        .sir (sir),
        .q   (q),
        .p   (p),
        .sol (sol),
        .sor (sor),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] cur);
        logic [7:0] r;
        r = cur;
        if (pre) r = 8'hFF;
        else if (en) begin
            case (mode)
                3'd1: r = d;
                3'd2: r = 8'((cur * 2) % 256) | {7'd0, sil};
                3'd3: r = (cur / 2) | (sir ? 8'h80 : 8'h00);
                3'd4: r = 8'((cur * 2) % 256) | (cur / 128);
                3'd5: r = (cur / 2) | ((cur % 2) ? 8'h80 : 8'h00);
                3'd6: r = 8'h00;
                3'd7: r = 8'hFF;
                default: r = cur;
            endcase
        end
        return r;
    endfunction

    // Reference model: register value plus a count of shifts since the last load/clear/preset
    always @(posedge clk) begin
        if (ret) begin
            m_q      <= 8'h00;
            m_shifts <= 0;
            m_wrap   <= 1'b0;
            m_valid  <= 1'b1;
        end else begin
            m_q <= model_next(m_q);
            if (pre || (en && (mode == 3'd1 || mode >= 3'd6))) begin
                m_shifts <= 0;
                m_wrap   <= 1'b0;
            end else if (en && mode >= 3'd2 && mode <= 3'd5) begin
                m_shifts <= (m_shifts + 1) % 8;
                m_wrap   <= (m_shifts + 1 == 8);
            end else begin
                m_wrap <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model once reset has been applied
    always @(negedge clk) begin
        if (m_valid) begin
            check("q", {24'd0, q}, {24'd0, m_q});
            check("p", {24'd0, p}, {24'd0, ~m_q});
            check("sol", {31'd0, sol}, {31'd0, m_q[7]});
            check("sor", {31'd0, sor}, {31'd0, m_q[0]});
            check("wrap", {31'd0, wrap}, {31'd0, m_wrap});
        end
    end

    task automatic cyc(input logic r, input logic pr, input logic e, input logic [2:0] m,
                       input logic [7:0] dd, input logic sl, input logic sr);
        ret = r; pre = pr; en = e; mode = m; d = dd; sil = sl; sir = sr;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        cyc(1, 1, 1, 3'd1, 8'hA5, 0, 0);
        cyc(1, 1, 1, 3'd1, 8'hA5, 0, 0);
        check("reset_q", {24'd0, q}, 32'h00);
        check("reset_p", {24'd0, p}, 32'hFF);
        check("reset_wrap", {31'd0, wrap}, 32'd0);

        cyc(0, 1, 1, 3'd1, 8'h3C, 0, 0);
        check("pre_q", {24'd0, q}, 32'hFF);
        check("pre_p", {24'd0, p}, 32'h00);
        cyc(0, 0, 1, 3'd1, 8'h3C, 0, 0);
        check("load_q", {24'd0, q}, 32'h3C);
        check("load_p", {24'd0, p}, 32'hC3);

        cyc(0, 0, 1, 3'd1, 8'h81, 0, 0);
        cyc(0, 0, 1, 3'd2, 8'h00, 0, 0);
        check("shl_q", {24'd0, q}, 32'h02);
        check("shl_sol", {31'd0, sol}, 32'd0);
        check("shl_sor", {31'd0, sor}, 32'd0);
        cyc(0, 0, 1, 3'd3, 8'h00, 0, 1);
        check("shr_q", {24'd0, q}, 32'h81);

        cyc(0, 0, 1, 3'd1, 8'h01, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 3'd4, 8'h00, 0, 0);
            check("rol_wrap", {31'd0, wrap}, (i == 7) ? 32'd1 : 32'd0);
        end
        check("rol_q", {24'd0, q}, 32'h01);
        cyc(0, 0, 1, 3'd0, 8'h00, 0, 0);
        check("rol_wrap_after", {31'd0, wrap}, 32'd0);

        cyc(0, 0, 1, 3'd1, 8'h5A, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3'd3, 8'h00, 0, 1);
        cyc(0, 1, 1, 3'd3, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 3'd3, 8'h00, 0, 0);
            check("abort_wrap", {31'd0, wrap}, (i == 7) ? 32'd1 : 32'd0);
        end

        cyc(0, 0, 1, 3'd1, 8'h0F, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 3'd2, 8'h00, 1, 0);
        check("gate_pre_q", {24'd0, q}, 32'h7F);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 3'd2, 8'h00, 0, 0);
            check("gate_hold_q", {24'd0, q}, 32'h7F);
            check("gate_hold_wrap", {31'd0, wrap}, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 3'd2, 8'h00, 0, 0);
            check("gate_wrap", {31'd0, wrap}, (i == 4) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 5));
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 7) != 0), m, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dlpre_ureg.md
# dlpre_ureg

Parametrised universal register: a WIDTH-bit bank of D flip-flops with a synchronous clear and preset, parallel load, logical shift and rotate modes, a true/complement output pair, and a shift-count wrap pulse. It replaces single-bit D latches with preset/clear wherever the design needs a multi-bit storage, serialiser or deserialiser stage, and sits directly on the datapath clock.

## Interface
- `WIDTH`, 8, register width in bits; legal range is 2 or more.
- `INIT`, {WIDTH{1'b0}}, value of `q` after reset.
- `PRE_VAL`, {WIDTH{1'b1}}, value of `q` after preset.
- `clk`  input  1  single clock; all state updates on rising edge.
- `ret`  input  1  reset; synchronous, active-high.
- `pre`  input  1  preset; synchronous, active-high.
- `en`  input  1  enables the `mode` operation.
- `mode`  input  3  operation select (see Operation).
- `d`  input  WIDTH  parallel load data.
- `sil`  input  1  serial in, enters bit 0 on shift-left.
- `sir`  input  1  serial in, enters bit WIDTH-1 on shift-right.
- `q`  output  WIDTH  register contents.
- `p`  output  WIDTH  bitwise complement of `q`; equals ~q in every cycle.
- `sol`  output  1  combinational q[WIDTH-1].
- `sor`  output  1  combinational q[0].
- `wrap`  output  1  one-cycle pulse when WIDTH shift/rotate operations have completed since the last load, clear or preset.

## Operation
- Priority per edge: `ret` > `pre` > (`en` and `mode`) > hold.
- `ret`=1: q<=INIT, p<=~INIT, cnt<=0, wrap<=0.
- `pre`=1 (no ret): q<=PRE_VAL, cnt<=0, wrap<=0.
- `en`=0: q, cnt hold; wrap<=0.
- `mode` with `en`=1:
  - 000: hold.
  - 001: load, q<=d.
  - 010: shift left, q<={q[W-2:0],sil}.
  - 011: shift right, q<={sir,q[W-1:1]}.
  - 100: rotate left.
  - 101: rotate right.
  - 110: clear to all zeros.
  - 111: set to all ones.
- Internal `cnt` width is max(1,$clog2(WIDTH)) and counts modes 010–101 modulo WIDTH. When cnt==WIDTH-1 and a shift/rotate executes, cnt<=0 and wrap<=1 on the same edge. All other cases give wrap<=0.
- Modes 001, 110 and 111 set cnt<=0. Mode 000 and `en`=0 hold cnt.
- `p` is a registered copy updated on the same edge as `q`, with value ~next_q. It never lags `q`.

## Timing
- Every operation has 1-cycle latency: an input sampled at edge N appears on `q`/`p` after edge N.
- `sol`/`sor` are combinational from `q` and add no extra latency.
- `wrap` is registered and is high for exactly one cycle, the cycle following the edge of the WIDTH-th shift. Back-to-back wraps are therefore WIDTH cycles apart under continuous shifting.
- `ret` and `pre` asserted mid-sequence abort the shift count immediately. A pending wrap is suppressed.
- Simultaneous `ret`+`pre`: reset wins. Simultaneous `pre`+`en`: preset wins, and `mode` is ignored.
- Before the first `ret`, the state is undefined. Benches must assert `ret` for at least 1 edge.

## Structure
- Shared package `dlpre_pkg` holds the 3-bit `mode_t` enum: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_CLR, MODE_SET.
- The package also holds the helper function `is_shift(mode_t)`.
- One natural sub-module is `dlpre_wrapcnt`: the modulo-WIDTH counter with `inc`/`clr` inputs and a registered `wrap` output. The next-state mux for `q` stays in the top level.

## Test plan
All scenarios use WIDTH=8 with default INIT and PRE_VAL.
- Reset: `ret`=1 for 2 cycles with `pre`=1, `en`=1, mode=LOAD, d=8'hA5 -> q=8'h00, p=8'hFF, wrap=0.
- Preset vs load: `pre`=1, `en`=1, mode=LOAD, d=8'h3C -> q=8'hFF, p=8'h00. Next cycle `pre`=0 -> q=8'h3C, p=8'hC3.
- Shift left: after LOAD 8'h81, SHL with sil=0 -> q=8'h02, sol=0, sor=0. SHR with sir=1 -> q=8'h81.
- Rotate and wrap: LOAD 8'h01, then 8 consecutive ROL -> q=8'h01 again, with wrap=1 only in the cycle after the 8th ROL.
- Count abort: LOAD, 5×SHR, then `pre`=1, then 8×SHR -> wrap asserts only after the 8th post-preset shift, never after the 3rd.
- Enable gating: 3×SHL, then `en`=0 for 4 cycles, then 5×SHL -> q holds while `en`=0, and wrap fires after the 5th resumed shift.
